// File: rtl/div_pkg.sv
// div_pkg
// Shared types and helpers for the shift-subtract divider.
//   div_state_t : controller states (IDLE, CALC, DONE)
//   cnt_width() : width of a counter that must represent 0..width
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic int cnt_width(input int width);
        int w;
        w = 0;
        while ((1 << w) < (width + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/div_step_counter.sv
// div_step_counter
// Iteration counter for the divider. Counts 0..WIDTH-1, one step per clock,
// while i_clear is low; o_last flags the final iteration.
// Ports:
//   i_clk   : rising-edge clock
//   i_reset : synchronous active-high reset
//   i_clear : hold the count at zero (asserted whenever no division runs)
//   o_last  : count has reached WIDTH-1
module div_step_counter
    import div_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_last
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_last = (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/shift_sub_divider.sv
// shift_sub_divider
// Sequential restoring divider: one quotient bit per clock, WIDTH clocks per
// division. A zero divisor finishes on the next clock with Quotient all ones,
// Remainder = Dividend and o_div_by_zero set.
// Optional macro SHIFT_SUB_DIVIDER_SIGNED_EN: two's complement operands. The
// core divides magnitudes; the quotient is negated when signs differ and the
// remainder takes the dividend's sign. Undefined: purely unsigned.
// Ports:
//   i_clk, i_reset         : clock, synchronous active-high reset
//   i_start                : request, accepted only in IDLE
//   i_dividend, i_divisor  : operands, captured on accepted start
//   o_quotient, o_remainder: registered results, held until next done/reset
//   o_done                 : one-cycle result-valid pulse
//   o_busy                 : high while iterating
//   o_div_by_zero          : registered zero-divisor flag, updated with done
module shift_sub_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_done,
    output logic             o_busy,
    output logic             o_div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_t r_state;
    div_state_t w_state_next;

    // Working remainder never exceeds the divisor after a step, so WIDTH bits
    // hold it; only the trial value needs the extra bit.
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic [WIDTH:0]   w_t;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_q_final;
    logic [WIDTH-1:0] w_r_final;
    logic [WIDTH-1:0] w_dividend_ld;
    logic [WIDTH-1:0] w_divisor_ld;
    logic             w_last;
    logic             w_div_zero;

    div_step_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step_counter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (r_state != CALC),
        .o_last  (w_last)
    );

    assign w_div_zero = (i_divisor == '0);

    assign w_t        = {r_rem, r_q[WIDTH-1]};
    assign w_ge       = (w_t >= {1'b0, r_d});
    // When w_ge holds the difference is below r_d, so WIDTH bits suffice.
    assign w_diff     = w_t[WIDTH-1:0] - r_d;
    assign w_rem_next = w_ge ? w_diff : w_t[WIDTH-1:0];
    assign w_q_next   = {r_q[WIDTH-2:0], w_ge};

`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    // -2^(WIDTH-1) maps to itself, which reads correctly as an unsigned magnitude.
    assign w_dividend_ld = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
    assign w_divisor_ld  = i_divisor[WIDTH-1]  ? -i_divisor  : i_divisor;
    assign w_q_final     = r_neg_q ? -w_q_next   : w_q_next;
    assign w_r_final     = r_neg_r ? -w_rem_next : w_rem_next;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (r_state == IDLE && i_start) begin
            r_neg_q <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
            r_neg_r <= i_dividend[WIDTH-1];
        end
    end
`else
    assign w_dividend_ld = i_dividend;
    assign w_divisor_ld  = i_divisor;
    assign w_q_final     = w_q_next;
    assign w_r_final     = w_rem_next;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_next = w_div_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rem         <= '0;
            r_q           <= '0;
            r_d           <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start && !w_div_zero) begin
                        r_rem <= '0;
                        r_q   <= w_dividend_ld;
                        r_d   <= w_divisor_ld;
                    end else if (i_start) begin
                        r_quotient    <= '1;
                        r_remainder   <= i_dividend;
                        r_div_by_zero <= 1'b1;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    if (w_last) begin
                        r_quotient    <= w_q_final;
                        r_remainder   <= w_r_final;
                        r_div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_div_by_zero = r_div_by_zero;
    assign o_done        = (r_state == DONE);
    assign o_busy        = (r_state == CALC);

endmodule

// File: tb/tb_shift_sub_divider.sv
module tb_shift_sub_divider;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       done;
    logic       busy;
    logic       dbz;

    int checks = 0;
    int errors = 0;
    int lat, bcnt, wcnt;

    shift_sub_divider #(.WIDTH(8)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_start       (start),
        .i_dividend    (dividend),
        .i_divisor     (divisor),
        .o_quotient    (quotient),
        .o_remainder   (remainder),
        .o_done        (done),
        .o_busy        (busy),
        .o_div_by_zero (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Holds start until accepted (wcnt = edges until busy/done), then counts
    // edges from the accepting edge to done (lat) and cycles with busy high.
    // pulse_at >= 0 re-pulses start with other operands mid-calculation.
    task automatic do_div(input logic [7:0] dd, input logic [7:0] dv, input int pulse_at,
                          output int lat_o, output int bcnt_o, output int wcnt_o);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        wcnt_o   = 0;
        do begin
            @(posedge clk); #1;
            wcnt_o++;
        end while (!busy && !done && wcnt_o < 10);
        start  = 1'b0;
        lat_o  = 0;
        bcnt_o = busy ? 1 : 0;
        while (!done && lat_o < 40) begin
            start = (lat_o == pulse_at);
            if (start) begin
                dividend = 8'd50;
                divisor  = 8'd5;
            end
            @(posedge clk); #1;
            lat_o++;
            if (busy) bcnt_o++;
        end
        start = 1'b0;
        chk("done_reached", {31'd0, done}, 32'd1);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q",    32'(quotient),  32'd0);
        chk("rst_r",    32'(remainder), 32'd0);
        chk("rst_done", 32'(done),      32'd0);
        chk("rst_busy", 32'(busy),      32'd0);
        chk("rst_dbz",  32'(dbz),       32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 200/7 = 28 r 4
        do_div(8'd200, 8'd7, -1, lat, bcnt, wcnt);
        chk("a_wait", 32'(wcnt), 32'd1);
        chk("a_lat",  32'(lat),  32'd8);
        chk("a_busy", 32'(bcnt), 32'd8);
        chk("a_q",    32'(quotient),  32'd28);
        chk("a_r",    32'(remainder), 32'd4);
        chk("a_dbz",  32'(dbz),       32'd0);

        // Back-to-back: start held through DONE is taken one edge later.
        do_div(8'd255, 8'd1, -1, lat, bcnt, wcnt);
        chk("b_wait", 32'(wcnt), 32'd2);
        chk("b_q",    32'(quotient),  32'd255);
        chk("b_r",    32'(remainder), 32'd0);

        do_div(8'd5, 8'd9, -1, lat, bcnt, wcnt);
        chk("c_wait", 32'(wcnt), 32'd2);
        chk("c_q",    32'(quotient),  32'd0);
        chk("c_r",    32'(remainder), 32'd5);
        @(posedge clk); #1;
        chk("c_done_pulse", 32'(done), 32'd0);

        // Divide by zero
        do_div(8'd100, 8'd0, -1, lat, bcnt, wcnt);
        chk("z_wait", 32'(wcnt), 32'd1);
        chk("z_lat",  32'(lat),  32'd0);
        chk("z_busy", 32'(bcnt), 32'd0);
        chk("z_q",    32'(quotient),  32'd255);
        chk("z_r",    32'(remainder), 32'd100);
        chk("z_dbz",  32'(dbz),       32'd1);
        @(posedge clk); #1;
        chk("z_done_pulse", 32'(done), 32'd0);
        chk("z_dbz_hold",   32'(dbz),  32'd1);
        chk("z_q_hold",     32'(quotient), 32'd255);

        // 250/10 = 25 r 0, clears the zero flag
        do_div(8'd250, 8'd10, -1, lat, bcnt, wcnt);
        chk("d_q",   32'(quotient),  32'd25);
        chk("d_r",   32'(remainder), 32'd0);
        chk("d_dbz", 32'(dbz),       32'd0);

        // Start re-pulsed mid-CALC with 50/5 must be ignored.
        do_div(8'd200, 8'd7, 3, lat, bcnt, wcnt);
        chk("e_lat", 32'(lat),       32'd8);
        chk("e_q",   32'(quotient),  32'd28);
        chk("e_r",   32'(remainder), 32'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("e_no_restart", 32'(busy), 32'd0);

        // Reset at iteration 4, with start also high (reset wins).
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("f_busy", 32'(busy), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b1;
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd3;
        @(posedge clk); #1;
        chk("f_q",    32'(quotient),  32'd0);
        chk("f_r",    32'(remainder), 32'd0);
        chk("f_done", 32'(done),      32'd0);
        chk("f_busy0",32'(busy),      32'd0);
        chk("f_dbz",  32'(dbz),       32'd0);
        @(posedge clk); #1;
        chk("f_reset_wins", 32'(busy), 32'd0);
        reset = 1'b0;
        start = 1'b0;

        do_div(8'd9, 8'd3, -1, lat, bcnt, wcnt);
        chk("g_lat", 32'(lat),       32'd8);
        chk("g_q",   32'(quotient),  32'd3);
        chk("g_r",   32'(remainder), 32'd0);

`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
        // -7/2 = -3 r -1
        do_div(8'hF9, 8'd2, -1, lat, bcnt, wcnt);
        chk("s1_lat", 32'(lat),       32'd8);
        chk("s1_q",   32'(quotient),  32'hFD);
        chk("s1_r",   32'(remainder), 32'hFF);
        // -128/-1 wraps to -128 r 0
        do_div(8'h80, 8'hFF, -1, lat, bcnt, wcnt);
        chk("s2_q",   32'(quotient),  32'h80);
        chk("s2_r",   32'(remainder), 32'h00);
        // 7/-2 = -3 r 1
        do_div(8'd7, 8'hFE, -1, lat, bcnt, wcnt);
        chk("s3_q",   32'(quotient),  32'hFD);
        chk("s3_r",   32'(remainder), 32'h01);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
